// File: rtl/lud_arbiter.sv
// lud_arbiter: round-robin share of one logical unit among four
// requesters, with a registered operand path and valid/ready response.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_valid/req_ready per-requester request handshake (ready one-hot)
//   req_opt/req_a/req_b packed per-requester opcode and operands
//   lu_opt/lu_a/lu_b    registered operands to the logical unit
//   lu_ans              combinational result from the logical unit
//   rsp_valid/rsp_ready response handshake
//   rsp_data/rsp_id     result and index of the issuing requester
//   busy                high while an operation is in flight
//   op_count            completed responses, wrapping
module lud_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [3*N_REQ-1:0] req_opt,
  input  logic [32*N_REQ-1:0] req_a,
  input  logic [32*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [2:0]         lu_opt,
  output logic [31:0]        lu_a,
  output logic [31:0]        lu_b,
  input  logic [31:0]        lu_ans,
  output logic               rsp_valid,
  output logic [31:0]        rsp_data,
  output logic [1:0]         rsp_id,
  input  logic               rsp_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [1:0]       rr_ptr_q;
  logic [2:0]       opt_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      data_q;
  logic [1:0]       id_q;
  logic [CNT_W-1:0] cnt_q;

  logic       any_req;
  logic       grant;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic [3:0] win_oh;

  logic [2:0]  sel_opt;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

  assign any_req = |req_valid;
  assign grant   = (state_q == IDLE) && any_req;

  // First valid requester at or above rr_ptr, wrapping at 4.
  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_oh = 4'b0001 << win;

  always_comb begin
    sel_opt = 3'd0;
    sel_a   = 32'd0;
    sel_b   = 32'd0;
    unique case (1'b1)
      win_oh[0]: begin
        sel_opt = req_opt[2:0];
        sel_a   = req_a[31:0];
        sel_b   = req_b[31:0];
      end
      win_oh[1]: begin
        sel_opt = req_opt[5:3];
        sel_a   = req_a[63:32];
        sel_b   = req_b[63:32];
      end
      win_oh[2]: begin
        sel_opt = req_opt[8:6];
        sel_a   = req_a[95:64];
        sel_b   = req_b[95:64];
      end
      win_oh[3]: begin
        sel_opt = req_opt[11:9];
        sel_a   = req_a[127:96];
        sel_b   = req_b[127:96];
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_req) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = '0;
    if (grant) req_ready = win_oh[N_REQ-1:0];
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 2'd0;
      opt_q    <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      data_q   <= 32'd0;
      id_q     <= 2'd0;
      cnt_q    <= '0;
    end else begin
      if (grant) begin
        opt_q    <= sel_opt;
        a_q      <= sel_a;
        b_q      <= sel_b;
        id_q     <= win;
        rr_ptr_q <= win + 2'd1;
      end
      if (state_q == EXEC) data_q <= lu_ans;
      if (state_q == RESP && rsp_ready)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign lu_opt   = opt_q;
  assign lu_a     = a_q;
  assign lu_b     = b_q;
  assign rsp_data = data_q;
  assign rsp_id   = id_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_lud_arbiter.sv
// Directed bench for lud_arbiter with a behavioural logical unit.
// Counter width is narrowed so the wrap case stays short.
module tb_lud_arbiter;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [11:0]   req_opt;
  logic [127:0]  req_a;
  logic [127:0]  req_b;
  logic [3:0]    req_ready;
  logic [2:0]    lu_opt;
  logic [31:0]   lu_a;
  logic [31:0]   lu_b;
  logic [31:0]   lu_ans;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic [1:0]    rsp_id;
  logic          rsp_ready;
  logic          busy;
  logic [CW-1:0] op_count;

  lud_arbiter #(.N_REQ(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_opt(req_opt),
    .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .lu_opt(lu_opt), .lu_a(lu_a), .lu_b(lu_b),
    .lu_ans(lu_ans),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    lu_ans = 32'd0;
    case (lu_opt)
      3'd0: lu_ans = lu_a & lu_b;
      3'd1: lu_ans = lu_a ^ lu_b;
      3'd2: lu_ans = ~(lu_a & lu_b);
      3'd3: lu_ans = lu_a | lu_b;
      3'd4: lu_ans = ~lu_b;
      3'd5: lu_ans = ~(lu_a | lu_b);
      3'd6: lu_ans = (~lu_b) + 32'd1;
      3'd7: lu_ans = ~(lu_a ^ lu_b);
      default: lu_ans = 32'd0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  id;
    logic [2:0]  opt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];
  int total = 0;
  int bad = 0;
  logic [CW-1:0] exp_cnt;
  int gc[5];
  logic [31:0] rr_exp[4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [2:0] o,
                         input logic [31:0] a,
                         input logic [31:0] b);
    req_opt[3*id +: 3] = o;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
  endtask

  task automatic wait_grant(input logic [3:0] exp,
                            input string nm);
    int n = 0;
    #1;
    while (req_ready == 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_gnt"}, 32'(req_ready), 32'(exp));
  endtask

  // Called in the grant cycle; ends at the first RESP negedge.
  task automatic after_grant(input logic [3:0] nv,
                             input logic [1:0] id,
                             input logic [31:0] d,
                             input string nm);
    @(posedge clk);
    #1 req_valid = nv;
    @(negedge clk);
    chk({nm, "_exbusy"}, 32'(busy), 32'd1);
    chk({nm, "_exvld"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_data"}, rsp_data, d);
    chk({nm, "_id"}, 32'(rsp_id), 32'(id));
  endtask

  task automatic run_op(input logic [3:0] mask,
                        input logic [1:0] id,
                        input logic [31:0] d,
                        input string nm);
    rsp_ready = 1'b1;
    req_valid = mask;
    wait_grant(4'b0001 << id, nm);
    after_grant(4'b0, id, d, nm);
    exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
    chk({nm, "_done"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_cnt"}, 32'(op_count), 32'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'd0, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    tbl[1] = '{2'd1, 3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    tbl[2] = '{2'd2, 3'd2, 32'hAAAA5555, 32'h0F0F0F0F, 32'hF5F5FAFA};
    tbl[3] = '{2'd3, 3'd3, 32'h12340000, 32'h00005678, 32'h12345678};
    tbl[4] = '{2'd0, 3'd4, 32'h00000000, 32'h0000FFFF, 32'hFFFF0000};
    tbl[5] = '{2'd1, 3'd5, 32'h0F000000, 32'h000000F0, 32'hF0FFFF0F};
    tbl[6] = '{2'd2, 3'd6, 32'h00000000, 32'h00000010, 32'hFFFFFFF0};
    tbl[7] = '{2'd3, 3'd7, 32'h12345678, 32'h12345678, 32'hFFFFFFFF};
    rr_exp[0] = 32'hF000F000;
    rr_exp[1] = 32'hFFFFFFFF;
    rr_exp[2] = 32'hFFFFFFFF;
    rr_exp[3] = 32'hFFFFFFFF;

    rst_n     = 1'b0;
    req_valid = '0;
    req_opt   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    exp_cnt   = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_opt", 32'(lu_opt), 32'd0);
    chk("rst_a", lu_a, 32'd0);
    chk("rst_b", lu_b, 32'd0);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // One opcode per vector, single requester at a time.
    for (int i = 0; i < 8; i++) begin
      set_req(int'(tbl[i].id), tbl[i].opt, tbl[i].a, tbl[i].b);
      run_op(4'b0001 << tbl[i].id, tbl[i].id, tbl[i].exp,
             $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_luopt", i), 32'(lu_opt), 32'(tbl[i].opt));
      chk($sformatf("vec%0d_lua", i), lu_a, tbl[i].a);
      chk($sformatf("vec%0d_lub", i), lu_b, tbl[i].b);
    end

    // All four requesting continuously.
    set_req(0, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00);
    set_req(1, 3'd6, 32'h0, 32'h00000001);
    set_req(2, 3'd4, 32'h0, 32'h0);
    set_req(3, 3'd7, 32'h12345678, 32'h12345678);
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_grant(4'b0001 << (g % 4), $sformatf("rr%0d", g));
      gc[g] = cyc;
      if (g > 0)
        chk($sformatf("rr%0d_gap", g), 32'(gc[g] - gc[g-1]), 32'd3);
      after_grant((g == 4) ? 4'h0 : 4'hF, 2'(g % 4),
                  rr_exp[g % 4], $sformatf("rr%0d", g));
      exp_cnt = exp_cnt + 1'b1;
    end
    @(negedge clk);
    chk("rr_cnt", 32'(op_count), 32'(exp_cnt));

    // Back-pressure: response held for five cycles.
    set_req(1, 3'd1, 32'hF0F0F0F0, 32'hFF00FF00);
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    wait_grant(4'b0010, "st");
    @(posedge clk);
    #1 req_valid = 4'b0100;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("st%0d_vld", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("st%0d_data", i), rsp_data, 32'h0FF00FF0);
      chk($sformatf("st%0d_id", i), 32'(rsp_id), 32'd1);
      chk($sformatf("st%0d_rdy", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    exp_cnt = exp_cnt + 1'b1;
    wait_grant(4'b0100, "st_next");
    chk("st_next_vld", 32'(rsp_valid), 32'd0);
    chk("st_next_cnt", 32'(op_count), 32'(exp_cnt));
    after_grant(4'b0, 2'd2, 32'hFFFFFFFF, "st_next");
    exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
    chk("st_cnt", 32'(op_count), 32'(exp_cnt));

    // Move rr_ptr to 2, then requesters 0 and 3 contend.
    set_req(1, 3'd3, 32'h1, 32'h2);
    run_op(4'b0010, 2'd1, 32'h3, "pre2");
    set_req(0, 3'd3, 32'h0000A000, 32'h00000A0A);
    set_req(3, 3'd5, 32'h0, 32'h0);
    req_valid = 4'b1001;
    wait_grant(4'b1000, "p2a");
    after_grant(4'b0001, 2'd3, 32'hFFFFFFFF, "p2a");
    exp_cnt = exp_cnt + 1'b1;
    wait_grant(4'b0001, "p2b");
    after_grant(4'b0, 2'd0, 32'h0000AA0A, "p2b");
    exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
    chk("p2_cnt", 32'(op_count), 32'(exp_cnt));

    // Asynchronous reset in the middle of EXEC.
    set_req(2, 3'd0, 32'hFFFFFFFF, 32'h12345678);
    req_valid = 4'b0100;
    wait_grant(4'b0100, "ar");
    @(posedge clk);
    #1 req_valid = 4'b0;
    chk("ar_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy0", 32'(busy), 32'd0);
    chk("ar_vld", 32'(rsp_valid), 32'd0);
    chk("ar_data", rsp_data, 32'd0);
    chk("ar_id", 32'(rsp_id), 32'd0);
    chk("ar_opt", 32'(lu_opt), 32'd0);
    chk("ar_a", lu_a, 32'd0);
    chk("ar_b", lu_b, 32'd0);
    chk("ar_cnt", 32'(op_count), 32'd0);
    chk("ar_rdy", 32'(req_ready), 32'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(2, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(4'b1100, 2'd2, 32'h0, "post");

    // Counter wrap.
    set_req(0, 3'd3, 32'h0, 32'h5);
    for (int i = 0; i < 20 && exp_cnt != '1; i++)
      run_op(4'b0001, 2'd0, 32'h5, $sformatf("fill%0d", i));
    chk("pre_wrap", 32'(op_count), 32'((1 << CW) - 1));
    run_op(4'b0001, 2'd0, 32'h5, "wrap");
    chk("wrap_zero", 32'(op_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lud_arbiter.md
# lud_arbiter

Shares one 32-bit logical unit among four requesters. Requests carry a 3-bit opcode and two 32-bit operands; the block grants one per transaction in round-robin order, registers the operands onto the unit's input ports, captures the 32-bit result and returns it with the requester ID over a valid/ready response channel. It sits between the issuing masters and the single logical-unit instance, so no requester drives the unit directly.

## Interface
Parameters:
- N_REQ, 4, number of requesters (fixed at 4; ID is 2 bits)
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  4  per-requester request valid
- req_opt  input  4x3 (12, requester i at [3i+2:3i])  opcode
- req_a  input  4x32 (128, requester i at [32i+31:32i])  operand a
- req_b  input  4x32 (128)  operand b
- req_ready  output  4  one-hot accept strobe, combinational
- lu_opt  output  3  to logical unit opt
- lu_a  output  32  to logical unit a
- lu_b  output  32  to logical unit b
- lu_ans  input  32  from logical unit, combinational in lu_opt/lu_a/lu_b
- rsp_valid  output  1  result valid
- rsp_data  output  32  result
- rsp_id  output  2  index of requester that issued the result
- rsp_ready  input  1  consumer accepts result
- busy  output  1  high in EXEC or RESP
- op_count  output  CNT_W  completed responses, wraps

## Operation
- Opcode map on lu_opt: 000 AND, 001 XOR, 010 NAND, 011 OR, 100 NOT b, 101 NOR, 110 two's complement of b, 111 XNOR. The arbiter passes opcodes through and does not decode them.
- States are IDLE, EXEC and RESP.
- IDLE:
  - If req_valid is nonzero, the winner is the first set bit scanning from rr_ptr upward, modulo 4.
  - req_ready[winner]=1 in that cycle only.
  - The winner's opt/a/b latch into op_reg.
  - rsp_id latches the winner index and rr_ptr becomes winner+1 (mod 4).
  - Next state is EXEC.
  - If req_valid==0, stay in IDLE; req_ready=0.
- EXEC: lu_ans is captured into rsp_data. Next state is RESP.
- RESP:
  - rsp_valid=1.
  - On rsp_ready=1: op_count increments and next state is IDLE.
  - Otherwise hold; rsp_data and rsp_id are stable.
- lu_opt, lu_a and lu_b always reflect op_reg and change only on an IDLE grant.
- req_ready is 0 outside IDLE. Requesters keep req_valid and operands stable until their req_ready.
- A requester that drops req_valid before grant is simply skipped; there is no penalty.
- op_count wraps from 2^CNT_W-1 to 0.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0
  - lu_opt=000, lu_a=0, lu_b=0
  - rsp_valid=0, rsp_data=0, rsp_id=0
  - busy=0, op_count=0, req_ready=0
- Grant in cycle T (IDLE) → capture at the end of T+1 (EXEC) → rsp_valid high from T+2.
- Minimum 3 cycles per operation; the next grant is earliest in the cycle after rsp_ready is sampled high.
- rsp_ready asserted in the first RESP cycle means rsp_valid is high for exactly one cycle.
- Simultaneous requests are granted strictly round-robin. After granting i, requester i has the lowest priority.
- A request arriving while busy waits; its arrival cycle does not affect order.
- Reset asserted mid-EXEC or mid-RESP returns immediately to reset values (asynchronous). The pending result is discarded and not counted.
- rsp_ready while in IDLE or EXEC is ignored.

## Test plan
- After reset, requester 0 sends opt=000, a=F0F0F0F0, b=FF00FF00 → req_ready=0001 at T, rsp_valid at T+2 with rsp_data=F000F000 and rsp_id=0, op_count=1.
- All 4 valid continuously with distinct ops and rsp_ready=1 → grants in order 0,1,2,3,0, one every 3 cycles. Checks: requester 1 opt=110, b=00000001 → FFFFFFFF; requester 2 opt=100, b=0 → FFFFFFFF; requester 3 opt=111, a=b=12345678 → FFFFFFFF.
- rsp_ready held 0 for 5 cycles in RESP → rsp_valid, rsp_data and rsp_id are stable, req_ready stays 0 and there are no new grants; raising rsp_ready returns the block to IDLE.
- rr_ptr=2 with requesters 0 and 3 valid → 3 is granted first, then 0.
- rst_n pulsed low during EXEC → all outputs take reset values at once, op_count=0, and the next request is granted normally.
- op_count preloaded by running 65535 ops (or forced) and one more completion → wraps to 0.
